// File: rtl/mac_8bit_tap_seq.sv
// -----------------------------------------------------------------------------
// mac_8bit_tap_seq
//   Sequencer/driver for one 8-bit MAC slice (initiator side of the MAC
//   control/data interface). A job is configured with a start pulse, then
//   operand/coefficient pairs stream in over a valid/ready port. Each
//   accepted pair is staged for one cycle and issued to the MAC as one
//   accumulate. The first tap seeds the accumulator with zero or the round
//   constant. After the last tap the MAC output byte is captured and
//   returned on a valid/ready result port.
//
// Ports
//   MAC_ACC_CLK, acc_ff_rstn     clock, async active-low reset
//   cfg_tap_cnt/out_sel/rnd/sat/tc  job configuration, latched on start
//   start, abort, busy           job control / status
//   in_valid/in_ready/in_oper/in_coef   tap pair stream
//   MAC_*, EFPGA_MATHB_CLK_EN    drive to the MAC slice
//   MAC_OUT                      MAC result byte
//   res_valid/res_ready/res_data result handshake
// -----------------------------------------------------------------------------
module mac_8bit_tap_seq #(
    parameter int TAP_W = 8
) (
    input  logic             MAC_ACC_CLK,
    input  logic             acc_ff_rstn,
    input  logic [TAP_W-1:0] cfg_tap_cnt,
    input  logic [5:0]       cfg_out_sel,
    input  logic             cfg_rnd,
    input  logic             cfg_sat,
    input  logic             cfg_tc,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_oper,
    input  logic [7:0]       in_coef,
    output logic [7:0]       MAC_OPER_DATA,
    output logic [7:0]       MAC_COEF_DATA,
    output logic             EFPGA_MATHB_CLK_EN,
    output logic             MAC_ACC_CLEAR,
    output logic             MAC_ACC_RND,
    output logic             MAC_ACC_SAT,
    output logic [5:0]       MAC_OUT_SEL,
    output logic             MAC_TC,
    input  logic [7:0]       MAC_OUT,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_CAPT   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Latched job configuration
    logic [TAP_W-1:0] r_tap_cnt;
    logic [5:0]       r_out_sel;
    logic             r_rnd;
    logic             r_sat;
    logic             r_tc;

    // Number of pairs accepted in the current job
    logic [TAP_W-1:0] r_acc_cnt;

    // One-deep issue stage
    logic             r_stg_vld;
    logic             r_stg_first;
    logic             r_stg_last;
    logic [7:0]       r_stg_oper;
    logic [7:0]       r_stg_coef;

    logic [7:0]       r_res_data;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_go_run;

    assign w_in_ready = (r_state == S_RUN) && (r_acc_cnt < r_tap_cnt);
    assign w_accept   = w_in_ready && in_valid;
    assign w_go_run   = (r_state == S_IDLE) && (w_state_nxt == S_RUN);

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
        if (!acc_ff_rstn) r_state <= S_IDLE;
        else              r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                // Zero-length jobs are dropped; abort wins over start.
                if (start && (cfg_tap_cnt != '0) && !abort) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (abort)                         w_state_nxt = S_IDLE;
                else if (r_stg_vld && r_stg_last)  w_state_nxt = S_CAPT;
            end
            S_CAPT: begin
                if (abort) w_state_nxt = S_IDLE;
                else       w_state_nxt = S_RESULT;
            end
            S_RESULT: begin
                if (abort || res_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Config latch, tap counter, issue stage, result capture
    // -------------------------------------------------------------------------
    always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
        if (!acc_ff_rstn) begin
            r_tap_cnt   <= '0;
            r_out_sel   <= '0;
            r_rnd       <= 1'b0;
            r_sat       <= 1'b0;
            r_tc        <= 1'b0;
            r_acc_cnt   <= '0;
            r_stg_vld   <= 1'b0;
            r_stg_first <= 1'b0;
            r_stg_last  <= 1'b0;
            r_stg_oper  <= '0;
            r_stg_coef  <= '0;
            r_res_data  <= '0;
        end else begin
            if (w_go_run) begin
                r_tap_cnt <= cfg_tap_cnt;
                r_out_sel <= cfg_out_sel;
                r_rnd     <= cfg_rnd;
                r_sat     <= cfg_sat;
                r_tc      <= cfg_tc;
                r_acc_cnt <= '0;
            end

            // The stage drains every cycle, so it only holds a tap for the
            // single cycle following its accept. Abort discards it.
            r_stg_vld <= w_accept && !abort;
            if (w_accept && !abort) begin
                r_stg_oper  <= in_oper;
                r_stg_coef  <= in_coef;
                r_stg_first <= (r_acc_cnt == '0);
                r_stg_last  <= (r_acc_cnt == (r_tap_cnt - TAP_W'(1)));
                r_acc_cnt   <= r_acc_cnt + TAP_W'(1);
            end

            // The accumulator holds the final sum during CAPT.
            if ((r_state == S_CAPT) && !abort) r_res_data <= MAC_OUT;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy               = (r_state != S_IDLE);
    assign in_ready           = w_in_ready;
    assign MAC_OPER_DATA      = r_stg_oper;
    assign MAC_COEF_DATA      = r_stg_coef;
    assign EFPGA_MATHB_CLK_EN = r_stg_vld;
    assign MAC_ACC_CLEAR      = r_stg_vld & r_stg_first & ~r_rnd;
    assign MAC_ACC_RND        = r_stg_vld & r_stg_first &  r_rnd;
    assign MAC_ACC_SAT        = r_sat;
    assign MAC_OUT_SEL        = r_out_sel;
    assign MAC_TC             = r_tc;
    assign res_valid          = (r_state == S_RESULT);
    assign res_data           = r_res_data;

endmodule

// File: tb/tb_mac_8bit_tap_seq.sv
// -----------------------------------------------------------------------------
// tb_mac_8bit_tap_seq
//   Bench for mac_8bit_tap_seq. Contains a behavioural MAC slice driven by the
//   DUT, a reference result model computed from whole-job arithmetic, and a
//   scoreboard: jobs push their expected byte, a monitor pops on each result
//   handshake and also checks per-cycle issue strobes.
// -----------------------------------------------------------------------------
module tb_mac_8bit_tap_seq;

    localparam int TAP_W = 8;

    logic             clk = 1'b0;
    logic             rstn;
    logic [TAP_W-1:0] cfg_tap_cnt;
    logic [5:0]       cfg_out_sel;
    logic             cfg_rnd, cfg_sat, cfg_tc;
    logic             start, abort, busy;
    logic             in_valid, in_ready;
    logic [7:0]       in_oper, in_coef;
    logic [7:0]       oper_d, coef_d;
    logic             clk_en, acc_clear, acc_rnd, acc_sat, mac_tc;
    logic [5:0]       out_sel;
    logic [7:0]       mac_out;
    logic             res_valid, res_ready;
    logic [7:0]       res_data;

    always #5 clk = ~clk;

    mac_8bit_tap_seq #(.TAP_W(TAP_W)) dut (
        .MAC_ACC_CLK(clk), .acc_ff_rstn(rstn),
        .cfg_tap_cnt(cfg_tap_cnt), .cfg_out_sel(cfg_out_sel), .cfg_rnd(cfg_rnd),
        .cfg_sat(cfg_sat), .cfg_tc(cfg_tc),
        .start(start), .abort(abort), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_oper(in_oper), .in_coef(in_coef),
        .MAC_OPER_DATA(oper_d), .MAC_COEF_DATA(coef_d),
        .EFPGA_MATHB_CLK_EN(clk_en), .MAC_ACC_CLEAR(acc_clear), .MAC_ACC_RND(acc_rnd),
        .MAC_ACC_SAT(acc_sat), .MAC_OUT_SEL(out_sel), .MAC_TC(mac_tc),
        .MAC_OUT(mac_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- arithmetic shared by MAC model and reference ----------
    function automatic longint prod(input logic [7:0] a, input logic [7:0] b, input logic tc);
        longint sa, sb;
        if (tc) begin sa = longint'($signed(a)); sb = longint'($signed(b)); end
        else    begin sa = longint'(a);          sb = longint'(b);          end
        return sa * sb;
    endfunction

    function automatic longint seed(input int sel);
        if (sel == 0) return 64'sd0;
        return longint'(1) <<< (sel - 1);
    endfunction

    function automatic logic [7:0] out_fn(input longint acc, input logic tc, input int sel,
                                          input logic sat);
        longint      s;
        logic [63:0] u;
        s = acc >>> sel;
        if (sat) begin
            if (tc) begin
                if (s > 127) s = 127; else if (s < -128) s = -128;
            end else begin
                if (s > 255) s = 255; else if (s < 0) s = 0;
            end
        end
        u = s;
        return u[7:0];
    endfunction

    // ---------------- behavioural MAC slice ---------------------------------
    longint mac_acc = 0;
    always @(posedge clk)
        if (clk_en)
            mac_acc <= (acc_clear ? 64'sd0 : acc_rnd ? seed(int'(out_sel)) : mac_acc)
                       + prod(oper_d, coef_d, mac_tc);
    assign mac_out = out_fn(mac_acc, mac_tc, int'(out_sel), acc_sat);

    // ---------------- reference model ---------------------------------------
    logic [7:0] ops[$];
    logic [7:0] cfs[$];
    logic [7:0] exp_q[$];

    function automatic logic [7:0] ref_result(input int n, input logic tc, input int sel,
                                              input logic rnd, input logic sat);
        longint sum = rnd ? seed(sel) : 64'sd0;
        for (int i = 0; i < n; i++) sum += prod(ops[i], cfs[i], tc);
        return out_fn(sum, tc, sel, sat);
    endfunction

    // ---------------- monitor ----------------------------------------------
    logic cur_rnd   = 1'b0;
    logic prev_fire;
    int   issue_idx = 0;

    always @(posedge clk or negedge rstn)
        if (!rstn) prev_fire <= 1'b0;
        else       prev_fire <= in_valid && in_ready && !abort;

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (!busy) issue_idx = 0;
            check("clk_en_vs_accept", clk_en, prev_fire);
            if (clk_en) begin
                check("clear_strobe", acc_clear, (issue_idx == 0) && !cur_rnd);
                check("rnd_strobe",   acc_rnd,   (issue_idx == 0) &&  cur_rnd);
                issue_idx++;
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) check("unexpected_result", 1, 0);
                else                   check("res_data", res_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_inrdy"}, in_ready, 0);
        check({tag, "_oper"},  oper_d, 0);
        check({tag, "_coef"},  coef_d, 0);
        check({tag, "_clken"}, clk_en, 0);
        check({tag, "_clear"}, acc_clear, 0);
        check({tag, "_rnd"},   acc_rnd, 0);
        check({tag, "_sat"},   acc_sat, 0);
        check({tag, "_sel"},   out_sel, 0);
        check({tag, "_tc"},    mac_tc, 0);
        check({tag, "_rval"},  res_valid, 0);
        check({tag, "_rdata"}, res_data, 0);
    endtask

    task automatic start_job(input int n, input logic tc, input int sel,
                             input logic rnd, input logic sat);
        cfg_tap_cnt = TAP_W'(n);
        cfg_out_sel = 6'(sel);
        cfg_rnd = rnd; cfg_sat = sat; cfg_tc = tc;
        cur_rnd = rnd;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("cfg_sel_latched", out_sel, 6'(sel));
        // Scramble config inputs: must not affect the running job.
        cfg_tap_cnt = TAP_W'($urandom); cfg_out_sel = 6'($urandom);
        cfg_rnd = 1'($urandom); cfg_sat = 1'($urandom); cfg_tc = 1'($urandom);
    endtask

    // Sends ops/cfs[first .. first+n-1]; returns just after the last accept edge.
    task automatic send_taps(input int first, input int n, input bit gaps);
        for (int i = first; i < first + n; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 3);
                for (int k = 0; k < g; k++) step();
            end
            in_valid = 1'b1; in_oper = ops[i]; in_coef = cfs[i];
            begin
                int w = 0;
                while (!in_ready && w < 50) begin step(); w++; end
                if (!in_ready) check("in_ready_timeout", 0, 1);
            end
            step();
            in_valid = 1'b0; in_oper = 8'($urandom); in_coef = 8'($urandom);
        end
    endtask

    task automatic run_job(input int n, input logic tc, input int sel, input logic rnd,
                           input logic sat, input bit gaps, input int rdy_dly,
                           input bit start_in_res);
        logic [7:0] held;
        exp_q.push_back(ref_result(n, tc, sel, rnd, sat));
        start_job(n, tc, sel, rnd, sat);
        send_taps(0, n, gaps);
        check("lat_edge0", res_valid, 0);
        step();
        check("lat_edge1", res_valid, 0);
        step();
        check("lat_edge2", res_valid, 1);
        held = res_data;
        for (int k = 0; k < rdy_dly; k++) begin
            if (start_in_res) begin start = 1'b1; cfg_tap_cnt = 8'd1; end
            step();
            check("res_hold_valid", res_valid, 1);
            check("res_hold_data",  res_data, held);
        end
        start = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("res_done_valid", res_valid, 0);
        check("res_done_busy",  busy, 0);
    endtask

    // ---------------- main sequence -----------------------------------------
    initial begin
        rstn = 1'b0; start = 0; abort = 0; in_valid = 0; res_ready = 0;
        in_oper = 0; in_coef = 0;
        cfg_tap_cnt = 0; cfg_out_sel = 0; cfg_rnd = 0; cfg_sat = 0; cfg_tc = 0;
        #1;
        check_all_zero("reset");
        step(); step();
        rstn = 1'b1;
        step();

        // zero-length start is ignored
        cfg_tap_cnt = 0; start = 1'b1; step(); start = 1'b0;
        check("zero_len_ignored", busy, 0);

        ops = '{8'd2, 8'd4, 8'd1}; cfs = '{8'd3, 8'd5, 8'd1};
        run_job(3, 0, 0, 0, 0, 0, 0, 0);                 // 0x1B
        ops = '{8'hF8, 8'd100}; cfs = '{8'd16, 8'd2};
        run_job(2, 1, 4, 1, 0, 0, 1, 0);                 // 0x05
        ops = '{8'd255}; cfs = '{8'd255};
        run_job(1, 0, 0, 0, 1, 0, 0, 0);                 // 0xFF
        run_job(1, 0, 0, 0, 0, 0, 0, 0);                 // 0x01
        ops = '{8'd127}; cfs = '{8'd127};
        run_job(1, 1, 0, 0, 1, 0, 0, 0);                 // 0x7F
        ops = '{8'h80}; cfs = '{8'd127};
        run_job(1, 1, 0, 0, 1, 0, 0, 0);                 // 0x80

        // backpressure: input gaps, res_ready held off 5 cycles, start in RESULT
        ops = '{8'd10, 8'd20, 8'd30, 8'd7}; cfs = '{8'd9, 8'd8, 8'd3, 8'd11};
        run_job(4, 0, 2, 1, 0, 1, 5, 1);

        // abort after 2 of 4 taps
        ops = '{8'd50, 8'd60, 8'd70, 8'd80}; cfs = '{8'd5, 8'd6, 8'd7, 8'd8};
        start_job(4, 0, 0, 0, 0);
        send_taps(0, 2, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_inrdy", in_ready, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("abort_no_result", res_valid, 0);
        end
        ops = '{8'd3}; cfs = '{8'd3};
        run_job(1, 0, 0, 0, 0, 0, 0, 0);                 // 0x09

        // asynchronous reset mid-RUN
        ops = '{8'd77, 8'd66, 8'd55}; cfs = '{8'd44, 8'd33, 8'd22};
        start_job(3, 1, 5, 1, 1);
        send_taps(0, 1, 0);
        #2 rstn = 1'b0;
        #1 check_all_zero("async_rst");
        step();
        rstn = 1'b1;
        step();
        ops = '{8'd12, 8'd13}; cfs = '{8'd2, 8'd3};
        run_job(2, 0, 1, 0, 0, 0, 0, 0);

        // randomized jobs
        for (int j = 0; j < 10; j++) begin
            int n = $urandom_range(1, 6);
            ops.delete(); cfs.delete();
            for (int i = 0; i < n; i++) begin
                ops.push_back(8'($urandom)); cfs.push_back(8'($urandom));
            end
            run_job(n, 1'($urandom), $urandom_range(0, 12), 1'($urandom), 1'($urandom),
                    1, $urandom_range(0, 3), 1'($urandom));
        end

        step(); step();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
